// File: rtl/if_id_queue.sv
// rtl/if_id_queue.sv - IF/ID circular instruction queue with flush; optional same-cycle bypass under IFQ_BYPASS_EN
// Entries are {pc, inst, taken}; storage is not reset, only pointers and occupancy are.
module if_id_queue #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  input  logic [31:0]              in_pc,
  input  logic [31:0]              in_inst,
  input  logic                     in_taken,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic [31:0]              out_pc,
  output logic [31:0]              out_inst,
  output logic                     out_taken,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [64:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [64:0]   head;
  logic          empty;
  logic          bypass;
  logic          push_store;
  logic          pop_store;

  assign empty    = (count_q == '0);
  assign in_ready = (count_q < CW'(DEPTH));
  assign head     = mem_q[rd_ptr_q];
  assign count    = count_q;

`ifdef IFQ_BYPASS_EN
  assign bypass = empty & in_valid & ~flush;
`else
  assign bypass = 1'b0;
`endif

  assign out_valid = ~empty | bypass;

  always_comb begin
    out_pc    = 32'h0;
    out_inst  = 32'h0;
    out_taken = 1'b0;
    if (!empty) begin
      {out_pc, out_inst, out_taken} = head;
    end else if (bypass) begin
      out_pc    = in_pc;
      out_inst  = in_inst;
      out_taken = in_taken;
    end
  end

  // A bypassed instruction that ID takes immediately never occupies a slot.
  assign push_store = in_valid & in_ready & ~flush & ~(bypass & out_ready);
  assign pop_store  = ~empty & out_ready & ~flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_store) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop_store) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({push_store, pop_store})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_store && !rst) begin
      mem_q[wr_ptr_q] <= {in_pc, in_inst, in_taken};
    end
  end

endmodule

// File: tb/tb_if_id_queue.sv
// tb/tb_if_id_queue.sv - scoreboard bench for if_id_queue (DEPTH=4), honours IFQ_BYPASS_EN
module tb_if_id_queue;

  localparam int DEPTH = 4;
`ifdef IFQ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        tk;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_pc;
  logic [31:0] in_inst;
  logic        in_taken;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic        out_taken;
  logic        out_ready;
  logic [2:0]  count;

  int errors = 0;
  int checks = 0;
  ent_t sb[$];
  logic [31:0] out_log[$];

  if_id_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_pc(in_pc), .in_inst(in_inst), .in_taken(in_taken),
    .in_ready(in_ready),
    .out_valid(out_valid), .out_pc(out_pc), .out_inst(out_inst), .out_taken(out_taken),
    .out_ready(out_ready), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one cycle, check outputs mid-cycle against the scoreboard, then update it.
  task automatic step(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                      input logic tk, input logic ordy, input logic fl);
    ent_t exp_head;
    logic exp_valid;
    logic byp;
    logic acc;
    in_valid  = v;
    in_pc     = pc;
    in_inst   = inst;
    in_taken  = tk;
    out_ready = ordy;
    flush     = fl;
    @(negedge clk);
    byp       = BYP && (sb.size() == 0) && v && !fl;
    acc       = v && (sb.size() < DEPTH) && !fl;
    exp_valid = (sb.size() != 0) || byp;
    if (sb.size() != 0)  exp_head = sb[0];
    else if (byp)        exp_head = '{pc: pc, inst: inst, tk: tk};
    else                 exp_head = '0;
    chk("count",     32'(count),     32'(sb.size()));
    chk("in_ready",  32'(in_ready),  32'(sb.size() < DEPTH));
    chk("out_valid", 32'(out_valid), 32'(exp_valid));
    chk("out_pc",    out_pc,         exp_head.pc);
    chk("out_inst",  out_inst,       exp_head.inst);
    chk("out_taken", 32'(out_taken), 32'(exp_head.tk));
    if (out_valid && ordy && !fl) out_log.push_back(out_pc);
    if (fl) begin
      sb.delete();
    end else begin
      if (sb.size() != 0 && ordy) void'(sb.pop_front());
      if (acc && !(byp && ordy)) sb.push_back('{pc: pc, inst: inst, tk: tk});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
  endtask

  initial begin
    logic saw_bad;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_pc = '0; in_inst = '0;
    in_taken = 1'b0; out_ready = 1'b0;
    @(posedge clk);
    do_reset();
    chk("rst_count",     32'(count),     32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_pc",    out_pc,         32'd0);
    chk("rst_out_inst",  out_inst,       32'd0);

    // Three pushes while ID stalled
    step(1, 32'h0, 32'h11, 0, 0, 0);
    step(1, 32'h4, 32'h22, 1, 0, 0);
    step(1, 32'h8, 32'h33, 0, 0, 0);
    chk("r37_count",    32'(count),    32'd3);
    chk("r37_head_pc",  out_pc,        32'h0);
    chk("r37_head_ins", out_inst,      32'h11);
    chk("r37_in_ready", 32'(in_ready), 32'd1);

    // Fill, then hold a push against a full queue
    step(1, 32'hc, 32'h44, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 32'h10, 32'h55, 0, 0, 0);
    chk("r38_count",    32'(count),    32'd4);
    chk("r38_in_ready", 32'(in_ready), 32'd0);
    out_log.delete();
    for (int i = 0; i < 5; i++) step(0, 32'h0, 32'h0, 0, 1, 0);
    chk("r38_drained", 32'(out_log.size()), 32'd4);
    saw_bad = 1'b0;
    foreach (out_log[i]) if (out_log[i] == 32'h10) saw_bad = 1'b1;
    chk("r38_no_0x10", 32'(saw_bad), 32'd0);

    // Streaming push/pop across pointer wraps
    out_log.delete();
    for (int i = 0; i < 10; i++) step(1, 32'(4 * i), 32'(32'h100 + i), 1'(i % 2), 1, 0);
    for (int i = 0; i < 3; i++) step(0, 32'h0, 32'h0, 0, 1, 0);
    chk("r39_len", 32'(out_log.size()), 32'd10);
    for (int i = 0; i < 10; i++) begin
      if (i < out_log.size()) chk($sformatf("r39_seq%0d", i), out_log[i], 32'(4 * i));
    end

    // Flush with a concurrent push
    step(1, 32'h20, 32'h1, 0, 0, 0);
    step(1, 32'h24, 32'h2, 0, 0, 0);
    step(1, 32'h28, 32'h3, 0, 0, 0);
    step(1, 32'h40, 32'h4, 0, 0, 1);
    chk("r40_count",     32'(count),     32'd0);
    chk("r40_out_valid", 32'(out_valid), 32'd0);
    chk("r40_out_inst",  out_inst,       32'd0);
    out_log.delete();
    for (int i = 0; i < 2; i++) step(0, 32'h0, 32'h0, 0, 1, 0);
    chk("r40_no_emerge", 32'(out_log.size()), 32'd0);

    // Push into empty queue with ID ready
    step(1, 32'h80, 32'h14400003, 1, 1, 0);
    chk("r41_count", 32'(count), BYP ? 32'd0 : 32'd1);
    step(0, 32'h0, 32'h0, 0, 1, 0);
    // Flush suppresses the bypass path
    step(1, 32'h90, 32'h5, 0, 1, 1);
    step(0, 32'h0, 32'h0, 0, 1, 0);

    // Reset mid-operation
    step(1, 32'hA0, 32'h6, 0, 0, 0);
    step(1, 32'hA4, 32'h7, 0, 0, 0);
    chk("r42_pre_count", 32'(count), 32'd2);
    do_reset();
    chk("r42_count",     32'(count),     32'd0);
    chk("r42_in_ready",  32'(in_ready),  32'd1);
    chk("r42_out_valid", 32'(out_valid), 32'd0);
    out_log.delete();
    for (int i = 0; i < 3; i++) step(0, 32'h0, 32'h0, 0, 1, 0);
    chk("r42_no_emerge", 32'(out_log.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
